// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: access codes, port selects,
// register-file size, status-byte layout and the access FSM state set.
package vdp_pkg;

   typedef enum logic [1:0] {
      VRAM_RD = 2'd0,
      VRAM_WR = 2'd1,
      REG_WR  = 2'd2,
      CRAM_WR = 2'd3
   } vdpCode_t;

   localparam logic DATA_PORT = 1'b0;
   localparam logic CTRL_PORT = 1'b1;

   localparam int NUM_REGS = 11;

   localparam int STAT_FRAME_BIT = 7;
   localparam int STAT_OVF_BIT   = 6;
   localparam int STAT_COL_BIT   = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2,
      RD_CAP  = 2'd3
   } accState_t;

   // Status byte as seen on a control-port read; unused low bits read as 0.
   function automatic logic [7:0] statusByte(input logic frame, input logic ovf, input logic col);
      logic [7:0] s;
      s = '0;
      s[STAT_FRAME_BIT] = frame;
      s[STAT_OVF_BIT]   = ovf;
      s[STAT_COL_BIT]   = col;
      return s;
   endfunction

endpackage

// File: rtl/vdp_cpu_access_fsm.sv
// VRAM access sequencer for the CPU port: holds one pending write or prefetch
// and issues it to VRAM only in cycles where the display pipeline is not busy.
module vdp_cpu_access_fsm #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              startWr,
   input  logic              startRd,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [7:0]        reqData,
   input  logic              screenBusy,
   output logic              ready,
   output logic [ADDR_W-1:0] vramAddr,
   output logic [7:0]        vramWdata,
   output logic              vramWe,
   output logic              vramRe,
   output logic              capValid
);
   import vdp_pkg::*;

   accState_t state, stateNext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Address and data are latched at accept so they stay stable while the
   // strobe waits out screenBusy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vramAddr  <= '0;
         vramWdata <= '0;
      end else if (startWr || startRd) begin
         vramAddr  <= reqAddr;
         vramWdata <= reqData;
      end
   end

   always_comb begin
      stateNext = state;
      ready     = 1'b0;
      vramWe    = 1'b0;
      vramRe    = 1'b0;
      capValid  = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (startWr) begin
               stateNext = WR_WAIT;
            end else if (startRd) begin
               stateNext = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (!screenBusy) begin
               vramWe    = 1'b1;
               stateNext = IDLE;
            end
         end
         RD_WAIT: begin
            if (!screenBusy) begin
               vramRe    = 1'b1;
               stateNext = RD_CAP;
            end
         end
         RD_CAP: begin
            capValid  = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: rtl/vdp_cpu_port.sv
// Z80-facing front end of the VDP: decodes data/control port accesses and owns
// the address/code registers, register file, read-ahead buffer and status flags.
module vdp_cpu_port #(
   parameter int NUM_REGS = vdp_pkg::NUM_REGS,
   parameter int ADDR_W   = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_wr,
   input  logic                     cpu_rd,
   input  logic                     cpu_port,
   input  logic [7:0]               cpu_din,
   output logic [7:0]               cpu_dout,
   output logic                     cpu_ready,
   input  logic                     screenBusy,
   output logic [ADDR_W-1:0]        VRAM_cpu_addr,
   output logic [7:0]               VRAM_cpu_wdata,
   output logic                     VRAM_cpu_we,
   output logic                     VRAM_cpu_re,
   input  logic [7:0]               VRAM_cpu_rdata,
   output logic [4:0]               CRAM_cpu_addr,
   output logic [5:0]               CRAM_cpu_wdata,
   output logic                     CRAM_cpu_we,
   output logic [NUM_REGS-1:0][7:0] regFile,
   input  logic                     sprCollision,
   input  logic                     sprOverflow,
   input  logic                     vblank,
   output logic                     irq
);
   import vdp_pkg::*;

   logic [ADDR_W-1:0] addr;
   vdpCode_t          code;
   logic              firstDone;
   logic [7:0]        readBuf;
   logic              frameFlag, ovfFlag, colFlag;

   logic              accept, ctrlWr, ctrlRd, dataWr, dataRd, secondWr;
   vdpCode_t          newCode;
   logic [ADDR_W-1:0] fullAddr;
   logic [3:0]        regSel;
   logic              regWrEn, ctrlPrefetch, startWr, startRd, capValid;

   assign accept   = cpu_ready && (cpu_wr || cpu_rd);
   assign ctrlWr   = accept && cpu_wr && (cpu_port == CTRL_PORT);
   assign ctrlRd   = accept && cpu_rd && (cpu_port == CTRL_PORT);
   assign dataWr   = accept && cpu_wr && (cpu_port == DATA_PORT);
   assign dataRd   = accept && cpu_rd && (cpu_port == DATA_PORT);
   assign secondWr = ctrlWr && firstDone;

   // The second control byte supplies both the code and the address high bits.
   assign newCode      = vdpCode_t'(cpu_din[7:6]);
   assign fullAddr     = {cpu_din[ADDR_W-9:0], addr[7:0]};
   assign regSel       = cpu_din[3:0];
   assign regWrEn      = secondWr && (newCode == REG_WR) && (int'(regSel) < NUM_REGS);
   assign ctrlPrefetch = secondWr && (newCode == VRAM_RD);

   assign startWr = dataWr && (code != CRAM_WR);
   assign startRd = ctrlPrefetch || dataRd;

   vdp_cpu_access_fsm #(.ADDR_W(ADDR_W)) accessFsm (
      .clk        (clk),
      .rst        (rst),
      .startWr    (startWr),
      .startRd    (startRd),
      .reqAddr    (ctrlPrefetch ? fullAddr : addr),
      .reqData    (cpu_din),
      .screenBusy (screenBusy),
      .ready      (cpu_ready),
      .vramAddr   (VRAM_cpu_addr),
      .vramWdata  (VRAM_cpu_wdata),
      .vramWe     (VRAM_cpu_we),
      .vramRe     (VRAM_cpu_re),
      .capValid   (capValid)
   );

   assign CRAM_cpu_we    = dataWr && (code == CRAM_WR);
   assign CRAM_cpu_addr  = addr[4:0];
   assign CRAM_cpu_wdata = cpu_din[5:0];

   assign irq = frameFlag && regFile[1][5];

   // A prefetch scheduled by the control port already points past its target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr      <= '0;
         code      <= VRAM_RD;
         firstDone <= 1'b0;
      end else if (ctrlWr) begin
         firstDone <= !firstDone;
         if (!firstDone) begin
            addr[7:0] <= cpu_din;
         end else begin
            code <= newCode;
            addr <= ctrlPrefetch ? fullAddr + ADDR_W'(1) : fullAddr;
         end
      end else if (dataWr || dataRd) begin
         firstDone <= 1'b0;
         addr      <= addr + ADDR_W'(1);
      end else if (ctrlRd) begin
         firstDone <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regFile <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (regWrEn && (regSel == 4'(i))) begin
               regFile[i] <= addr[7:0];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         readBuf <= '0;
      end else if (capValid) begin
         readBuf <= VRAM_cpu_rdata;
      end else if (dataWr) begin
         readBuf <= cpu_din;
      end
   end

   // A set arriving with a status read wins over the read's clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frameFlag <= 1'b0;
         ovfFlag   <= 1'b0;
         colFlag   <= 1'b0;
      end else begin
         frameFlag <= vblank       || (frameFlag && !ctrlRd);
         ovfFlag   <= sprOverflow  || (ovfFlag   && !ctrlRd);
         colFlag   <= sprCollision || (colFlag   && !ctrlRd);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_dout <= '0;
      end else if (ctrlRd) begin
         cpu_dout <= statusByte(frameFlag, ovfFlag, colFlag);
      end else if (dataRd) begin
         cpu_dout <= readBuf;
      end
   end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed CPU port sequences against a transaction
// model of the port, plus literal expectations for the key scenarios.
module tb_vdp_cpu_port;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_port = 1'b0;
   logic [7:0]        cpu_din = '0;
   logic [7:0]        cpu_dout;
   logic              cpu_ready;
   logic              screenBusy = 1'b0;
   logic [13:0]       VRAM_cpu_addr;
   logic [7:0]        VRAM_cpu_wdata;
   logic              VRAM_cpu_we, VRAM_cpu_re;
   logic [7:0]        VRAM_cpu_rdata = '0;
   logic [4:0]        CRAM_cpu_addr;
   logic [5:0]        CRAM_cpu_wdata;
   logic              CRAM_cpu_we;
   logic [10:0][7:0]  regFile;
   logic              sprCollision = 1'b0, sprOverflow = 1'b0, vblank = 1'b0;
   logic              irq;

   int vectors = 0;
   int errors  = 0;

   vdp_cpu_port #(.NUM_REGS(11), .ADDR_W(14)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_wr         (cpu_wr),
      .cpu_rd         (cpu_rd),
      .cpu_port       (cpu_port),
      .cpu_din        (cpu_din),
      .cpu_dout       (cpu_dout),
      .cpu_ready      (cpu_ready),
      .screenBusy     (screenBusy),
      .VRAM_cpu_addr  (VRAM_cpu_addr),
      .VRAM_cpu_wdata (VRAM_cpu_wdata),
      .VRAM_cpu_we    (VRAM_cpu_we),
      .VRAM_cpu_re    (VRAM_cpu_re),
      .VRAM_cpu_rdata (VRAM_cpu_rdata),
      .CRAM_cpu_addr  (CRAM_cpu_addr),
      .CRAM_cpu_wdata (CRAM_cpu_wdata),
      .CRAM_cpu_we    (CRAM_cpu_we),
      .regFile        (regFile),
      .sprCollision   (sprCollision),
      .sprOverflow    (sprOverflow),
      .vblank         (vblank),
      .irq            (irq)
   );

   always #20 clk = ~clk;

   // Synchronous VRAM: data appears the cycle after a read strobe.
   logic [7:0] vmem [16384];
   always @(posedge clk) begin
      if (VRAM_cpu_we) vmem[VRAM_cpu_addr] <= VRAM_cpu_wdata;
      if (VRAM_cpu_re) VRAM_cpu_rdata <= vmem[VRAM_cpu_addr];
   end

   task automatic checkOutput(input string name, input logic [87:0] act, input logic [87:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Transaction model of the port.
   logic [13:0] mAddr = '0;
   logic [1:0]  mCode = '0;
   bit          mFirst = 0;
   logic [7:0]  mReadBuf = '0, mDout = '0;
   logic [7:0]  mRegs [11];
   bit          mFrame = 0, mOvf = 0, mCol = 0;
   bit          statusRd;
   bit          ignoreStrobe = 0;
   logic [21:0] wrQ [$];
   logic [13:0] rdQ [$];
   logic [10:0] crQ [$];

   initial for (int i = 0; i < 11; i++) mRegs[i] = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mAddr = '0; mCode = '0; mFirst = 0; mReadBuf = '0; mDout = '0;
         for (int i = 0; i < 11; i++) mRegs[i] = '0;
         mFrame = 0; mOvf = 0; mCol = 0;
         wrQ.delete(); rdQ.delete(); crQ.delete();
      end else begin
         statusRd = 0;
         if (!ignoreStrobe && cpu_wr) begin
            if (cpu_port) begin
               if (!mFirst) begin
                  mAddr[7:0] = cpu_din;
                  mFirst = 1;
               end else begin
                  mFirst = 0;
                  mCode  = cpu_din[7:6];
                  mAddr  = {cpu_din[5:0], mAddr[7:0]};
                  if (mCode == 2'd0) begin
                     rdQ.push_back(mAddr);
                     mReadBuf = vmem[mAddr];
                     mAddr = mAddr + 14'd1;
                  end else if (mCode == 2'd2 && cpu_din[3:0] < 4'd11) begin
                     mRegs[cpu_din[3:0]] = mAddr[7:0];
                  end
               end
            end else begin
               mFirst = 0;
               mReadBuf = cpu_din;
               if (mCode != 2'd3) wrQ.push_back({mAddr, cpu_din});
               mAddr = mAddr + 14'd1;
            end
         end else if (!ignoreStrobe && cpu_rd) begin
            mFirst = 0;
            if (cpu_port) begin
               mDout = {mFrame, mOvf, mCol, 5'b0};
               statusRd = 1;
            end else begin
               mDout = mReadBuf;
               rdQ.push_back(mAddr);
               mReadBuf = vmem[mAddr];
               mAddr = mAddr + 14'd1;
            end
         end
         if (statusRd) begin
            mFrame = 0; mOvf = 0; mCol = 0;
         end
         if (vblank) mFrame = 1;
         if (sprOverflow) mOvf = 1;
         if (sprCollision) mCol = 1;
      end
   end

   int         weCount = 0, reCount = 0, cramCount = 0;
   logic [13:0] lastWeAddr = '0, lastReAddr = '0;
   logic [4:0]  lastCramAddr = '0;
   logic [5:0]  lastCramData = '0;

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic [87:0] expRegs;
      for (int i = 0; i < 11; i++) expRegs[i*8 +: 8] = mRegs[i];
      checkOutput("regFile", regFile, expRegs);
      checkOutput("irq", irq, mFrame & mRegs[1][5]);
      checkOutput("cpu_dout", cpu_dout, mDout);
      if (VRAM_cpu_we) begin
         weCount++;
         lastWeAddr = VRAM_cpu_addr;
         if (wrQ.size() == 0) checkOutput("unexpected VRAM we", 1, 0);
         else checkOutput("VRAM write addr/data", {VRAM_cpu_addr, VRAM_cpu_wdata}, wrQ.pop_front());
      end
      if (VRAM_cpu_re) begin
         reCount++;
         lastReAddr = VRAM_cpu_addr;
         if (rdQ.size() == 0) checkOutput("unexpected VRAM re", 1, 0);
         else checkOutput("VRAM prefetch addr", VRAM_cpu_addr, rdQ.pop_front());
      end
      if (CRAM_cpu_we) begin
         cramCount++;
         lastCramAddr = CRAM_cpu_addr;
         lastCramData = CRAM_cpu_wdata;
         if (crQ.size() == 0) checkOutput("unexpected CRAM we", 1, 0);
         else checkOutput("CRAM write addr/data", {CRAM_cpu_addr, CRAM_cpu_wdata}, crQ.pop_front());
      end
   end

   task automatic waitReady();
      int n = 0;
      @(negedge clk);
      while (!cpu_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_ready) checkOutput("cpu_ready timeout", 0, 1);
   endtask

   task automatic applyStimulus(input bit rd, input bit port, input logic [7:0] din);
      waitReady();
      @(posedge clk); #1;
      if (!rd && !port && mCode == 2'd3) crQ.push_back({mAddr[4:0], din[5:0]});
      cpu_wr = !rd; cpu_rd = rd; cpu_port = port; cpu_din = din;
      @(posedge clk); #1;
      cpu_wr = 0; cpu_rd = 0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int w0, c0;
      for (int i = 0; i < 16384; i++) vmem[i] = 8'(i) ^ 8'h5A;
      vmem[14'h3FFF] = 8'h12;
      vmem[14'h0000] = 8'h34;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset cpu_ready", cpu_ready, 1);
      checkOutput("reset strobes", {VRAM_cpu_we, VRAM_cpu_re, CRAM_cpu_we}, 0);
      checkOutput("reset cpu_dout", cpu_dout, 0);
      checkOutput("reset regFile", regFile, 0);
      @(posedge clk); #1 rst = 0;

      $display("[TB] register write");
      applyStimulus(0, 1, 8'h26);
      applyStimulus(0, 1, 8'h81);
      checkOutput("regFile[1]", regFile[1], 8'h26);
      checkOutput("no VRAM strobe on reg write", weCount + reCount, 0);

      $display("[TB] data write with auto-increment");
      applyStimulus(0, 1, 8'h00);
      applyStimulus(0, 1, 8'h7F);
      w0 = weCount;
      applyStimulus(0, 0, 8'hAA);
      applyStimulus(0, 0, 8'h55);
      waitReady();
      checkOutput("VRAM write count", weCount - w0, 2);
      checkOutput("last VRAM write addr", lastWeAddr, 14'h3F01);
      applyStimulus(1, 0, 8'h00);
      checkOutput("read after write returns written byte", cpu_dout, 8'h55);
      waitReady();
      checkOutput("addr after two writes", lastReAddr, 14'h3F02);

      $display("[TB] read-ahead and wrap");
      applyStimulus(0, 1, 8'hFF);
      applyStimulus(0, 1, 8'h3F);
      waitReady();
      checkOutput("control prefetch addr", lastReAddr, 14'h3FFF);
      applyStimulus(1, 0, 8'h00);
      checkOutput("first data read", cpu_dout, 8'h12);
      applyStimulus(1, 0, 8'h00);
      checkOutput("second data read", cpu_dout, 8'h34);
      waitReady();
      checkOutput("prefetch after wrap", lastReAddr, 14'h0001);

      $display("[TB] arbitration");
      applyStimulus(0, 1, 8'h00);
      applyStimulus(0, 1, 8'h40);
      waitReady();
      screenBusy = 1;
      w0 = weCount;
      applyStimulus(0, 0, 8'h77);
      ignoreStrobe = 1; cpu_wr = 1; cpu_port = 1; cpu_din = 8'h99;
      @(posedge clk); #1;
      cpu_wr = 0; ignoreStrobe = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("busy cpu_ready", cpu_ready, 0);
         checkOutput("busy we", VRAM_cpu_we, 0);
      end
      @(posedge clk); #1 screenBusy = 0;
      @(negedge clk);
      checkOutput("we after busy falls", VRAM_cpu_we, 1);
      checkOutput("write addr after busy", VRAM_cpu_addr, 14'h0000);
      @(negedge clk);
      checkOutput("cpu_ready after write", cpu_ready, 1);
      checkOutput("single write issued", weCount - w0, 1);

      $display("[TB] CRAM write");
      c0 = cramCount;
      applyStimulus(0, 1, 8'h10);
      applyStimulus(0, 1, 8'hC0);
      applyStimulus(0, 0, 8'h3F);
      checkOutput("CRAM first addr/data", {lastCramAddr, lastCramData}, {5'h10, 6'h3F});
      applyStimulus(0, 0, 8'h01);
      checkOutput("CRAM second addr/data", {lastCramAddr, lastCramData}, {5'h11, 6'h01});
      applyStimulus(0, 1, 8'h1F);
      applyStimulus(0, 1, 8'hC0);
      applyStimulus(0, 0, 8'h05);
      applyStimulus(0, 0, 8'h06);
      checkOutput("CRAM wrap addr/data", {lastCramAddr, lastCramData}, {5'h00, 6'h06});
      checkOutput("CRAM write count", cramCount - c0, 4);

      $display("[TB] register index boundary");
      applyStimulus(0, 1, 8'hAB);
      applyStimulus(0, 1, 8'h8A);
      checkOutput("regFile[10]", regFile[10], 8'hAB);
      applyStimulus(0, 1, 8'h55);
      applyStimulus(0, 1, 8'h8B);
      checkOutput("regFile[10] after out-of-range write", regFile[10], 8'hAB);

      $display("[TB] status and interrupt");
      @(posedge clk); #1 vblank = 1;
      @(posedge clk); #1 vblank = 0;
      @(negedge clk);
      checkOutput("irq after vblank", irq, 1);
      applyStimulus(0, 1, 8'h34);
      applyStimulus(1, 1, 8'h00);
      checkOutput("status after vblank", cpu_dout, 8'h80);
      @(negedge clk);
      checkOutput("irq after status read", irq, 0);
      waitReady();
      @(posedge clk); #1 cpu_rd = 1; cpu_port = 1; vblank = 1;
      @(posedge clk); #1 cpu_rd = 0; vblank = 0;
      checkOutput("status coincident with vblank", cpu_dout, 8'h00);
      @(negedge clk);
      checkOutput("irq kept by coincident vblank", irq, 1);
      applyStimulus(1, 1, 8'h00);
      checkOutput("frame flag survived", cpu_dout, 8'h80);
      @(posedge clk); #1 sprOverflow = 1; sprCollision = 1;
      @(posedge clk); #1 sprOverflow = 0; sprCollision = 0;
      applyStimulus(1, 1, 8'h00);
      checkOutput("sticky sprite flags", cpu_dout, 8'h60);
      applyStimulus(1, 1, 8'h00);
      checkOutput("flags cleared", cpu_dout, 8'h00);

      $display("[TB] reset mid-write");
      applyStimulus(0, 1, 8'h00);
      applyStimulus(0, 1, 8'h40);
      waitReady();
      screenBusy = 1;
      applyStimulus(0, 0, 8'h66);
      w0 = weCount;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      @(negedge clk);
      checkOutput("reset mid-write strobes", {VRAM_cpu_we, VRAM_cpu_re, CRAM_cpu_we}, 0);
      checkOutput("reset mid-write cpu_ready", cpu_ready, 1);
      checkOutput("reset mid-write regFile", regFile, 0);
      checkOutput("reset mid-write irq", irq, 0);
      screenBusy = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (5) @(negedge clk);
      checkOutput("no write after reset", weCount - w0, 0);
      applyStimulus(0, 1, 8'h26);
      applyStimulus(0, 1, 8'h81);
      checkOutput("regFile[1] after reset", regFile[1], 8'h26);

      waitReady();
      repeat (2) @(negedge clk);
      checkOutput("pending VRAM writes", wrQ.size(), 0);
      checkOutput("pending prefetches", rdQ.size(), 0);
      checkOutput("pending CRAM writes", crQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
